fc_layer_engine: RTL and testbench
==================================

Name: fc_layer_engine

Overview:
- Parametrised single fully-connected layer engine, successor to the fixed 14/10/5 FC top.
- Holds an input-activation buffer, loaded from the flatten stage, and a weight/bias memory, loaded from the host or controller.
- On start, computes OUT_CELL signed fixed-point neurons with one MAC per cycle, with optional ReLU and output saturation.
- Streams each result to the next layer or FC memory as a valid/addr/value triple, then pulses all_end to the controller.

Parameters:
- IN_CELL, 14, number of input activations per neuron.
- OUT_CELL, 10, number of output neurons.
- DATA_W, 16, signed data/weight width.
- FRAC_BITS, 8, fractional bits of the fixed-point format (Q(DATA_W-FRAC_BITS).FRAC_BITS).
- ACC_W, 40, accumulator width. Must be ≥ 2*DATA_W + clog2(IN_CELL+1).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  compute request; accepted only in IDLE
- relu_en  input  1  ReLU mode; sampled when start is accepted
- flat_we  input  1  input-buffer write enable
- flat_addr  input  16  input index, 0..IN_CELL-1
- flat_value  input  DATA_W  input activation
- wt_we  input  1  weight-memory write enable
- wt_addr  input  16  o*(IN_CELL+1)+i; i==IN_CELL selects the bias of neuron o
- wt_value  input  DATA_W  weight or bias
- busy  output  1  computation in progress
- out_valid  output  1  out_value/out_addr valid this cycle
- out_addr  output  16  neuron index of out_value
- out_value  output  DATA_W  neuron result
- all_end  output  1  one-cycle pulse: layer finished
- load_err  output  1  one-cycle pulse: write rejected

Behaviour:
- Reset: busy, out_valid, all_end and load_err are 0; out_addr and out_value are 0; FSM goes to IDLE. Buffer and weight memory are not cleared; contents are retained/undefined.
- Reset asserted mid-operation aborts the layer immediately. No all_end is produced.
- Writes:
  - Accepted in IDLE only, one clock edge per write.
  - Out-of-range addresses are ignored: flat_addr ≥ IN_CELL, wt_addr ≥ OUT_CELL*(IN_CELL+1).
  - Any flat_we or wt_we while busy is ignored and pulses load_err on the next cycle.
  - flat_we and wt_we in the same cycle are both accepted; they target separate memories.
- FSM states: IDLE, MAC, FINISH.
  - IDLE→MAC on start. Neuron index o=0, input index i=0, accumulator cleared, relu_en latched, busy=1 from the next cycle.
  - MAC: acc += sign-extended (x[i]*w[o][i]) for IN_CELL cycles; i counts 0..IN_CELL-1. Then →FINISH.
  - FINISH takes one cycle:
    - r = (acc + (bias[o] <<< FRAC_BITS)) >>> FRAC_BITS (arithmetic shift, truncation toward −∞).
    - Saturate r to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
    - If the latched relu_en is set and r<0, r=0.
    - Register r into out_value and o into out_addr; out_valid=1 for exactly the next cycle.
    - If o<OUT_CELL−1: o++, clear acc, →MAC.
    - Otherwise: all_end=1 in the same cycle as the last out_valid, busy=0 in that cycle, →IDLE.
- Timing, with start accepted at edge E0:
  - Output k's out_valid is high in the cycle after edge E0+(k+1)*(IN_CELL+1).
  - Total layer latency is OUT_CELL*(IN_CELL+1)+1 cycles.
  - A new start is legal in the cycle all_end is high, and is accepted at the following edge.
- start while busy is ignored; no error is flagged.
- Overflow handling: the accumulator never wraps for legal ACC_W. Only the final result saturates.

Test Plan:
Bench parameters: IN_CELL=4, OUT_CELL=2, DATA_W=16, FRAC_BITS=8.
1. Basic MAC:
   - Stimulus: x={0x0100,0x0200,0xFF00,0x0080}; neuron0 weights all 0x0100, bias 0; neuron1 weights all 0xFF00, bias 0x0100; relu_en=0; start.
   - Required: out (0,0x0280), then (1,0xFE80); all_end with the second output.
2. ReLU:
   - Stimulus: same data as scenario 1, relu_en=1.
   - Required: outputs 0x0280, then 0x0000.
3. Saturation:
   - Stimulus: all x and weights 0x7FFF, bias 0x7FFF.
   - Required: both outputs 0x7FFF. With weights 0x8000, both outputs 0x8000.
4. Latency:
   - Stimulus: start at edge E0.
   - Required: out_valid in the cycles after E0+5 and E0+10 only; busy high for exactly 10 cycles; all_end single pulse.
5. Write/start protection:
   - Stimulus: flat_we mid-computation; wt_addr=10 in IDLE; start while busy.
   - Required: the mid-computation flat_we gives load_err pulse, buffer unchanged, results as in scenario 1; wt_addr=10 has no effect and no load_err; start while busy has no effect.
6. Reset mid-run:
   - Stimulus: reset_n low during MAC of neuron1.
   - Required: all outputs 0, IDLE, no all_end.
   - Follow-up: a restart without reloading reproduces scenario 1 results.

Source files
------------

// File: rtl/fc_layer_engine.sv
// Single fully-connected layer: input-activation buffer, weight/bias memory and a one-MAC-per-cycle
// datapath producing OUT_CELL saturated (optionally ReLU'd) fixed-point neurons.
module fc_layer_engine #(
  parameter int unsigned IN_CELL   = 14,
  parameter int unsigned OUT_CELL  = 10,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned ACC_W     = 40
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              relu_en,
  input  logic              flat_we,
  input  logic [15:0]       flat_addr,
  input  logic [DATA_W-1:0] flat_value,
  input  logic              wt_we,
  input  logic [15:0]       wt_addr,
  input  logic [DATA_W-1:0] wt_value,
  output logic              busy,
  output logic              out_valid,
  output logic [15:0]       out_addr,
  output logic [DATA_W-1:0] out_value,
  output logic              all_end,
  output logic              load_err
);

  localparam int unsigned WDepth = OUT_CELL * (IN_CELL + 1);
  localparam int unsigned FA     = (IN_CELL > 1) ? $clog2(IN_CELL) : 1;
  localparam int unsigned OA     = (OUT_CELL > 1) ? $clog2(OUT_CELL) : 1;
  localparam int unsigned WA     = $clog2(WDepth);

  localparam logic signed [ACC_W-1:0] SatMax =
      {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin =
      {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMac, StFinish} state_e;

  state_e                   state_q, state_d;
  logic [FA-1:0]            i_q, i_d;
  logic [OA-1:0]            o_q, o_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     relu_q, relu_d;
  logic                     out_valid_q, out_valid_d;
  logic [15:0]              out_addr_q, out_addr_d;
  logic [DATA_W-1:0]        out_value_q, out_value_d;
  logic                     all_end_q, all_end_d;
  logic                     load_err_q, load_err_d;

  logic signed [DATA_W-1:0] flat_mem [IN_CELL];
  logic signed [DATA_W-1:0] wt_mem   [WDepth];

  logic [WA-1:0]              w_idx, b_idx;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    sum, shifted;
  logic signed [DATA_W-1:0]   res;

  // Memories are deliberately not reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (state_q == StIdle) begin
      if (flat_we && ({16'd0, flat_addr} < IN_CELL)) begin
        flat_mem[flat_addr[FA-1:0]] <= flat_value;
      end
      if (wt_we && ({16'd0, wt_addr} < WDepth)) begin
        wt_mem[wt_addr[WA-1:0]] <= wt_value;
      end
    end
  end

  always_comb begin
    w_idx = WA'(32'(o_q) * (IN_CELL + 1) + 32'(i_q));
    b_idx = WA'(32'(o_q) * (IN_CELL + 1) + IN_CELL);
    prod  = flat_mem[i_q] * wt_mem[w_idx];

    sum     = acc_q + (ACC_W'(wt_mem[b_idx]) <<< FRAC_BITS);
    shifted = sum >>> FRAC_BITS;
    if (shifted > SatMax) begin
      res = SatMax[DATA_W-1:0];
    end else if (shifted < SatMin) begin
      res = SatMin[DATA_W-1:0];
    end else begin
      res = shifted[DATA_W-1:0];
    end
    if (relu_q && res[DATA_W-1]) begin
      res = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    o_d         = o_q;
    acc_d       = acc_q;
    relu_d      = relu_q;
    out_valid_d = 1'b0;
    out_addr_d  = out_addr_q;
    out_value_d = out_value_q;
    all_end_d   = 1'b0;
    load_err_d  = (state_q != StIdle) && (flat_we || wt_we);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StMac;
          i_d     = '0;
          o_d     = '0;
          acc_d   = '0;
          relu_d  = relu_en;
        end
      end
      StMac: begin
        acc_d = acc_q + ACC_W'(prod);
        if (i_q == FA'(IN_CELL - 1)) begin
          state_d = StFinish;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      StFinish: begin
        out_value_d = res;
        out_addr_d  = 16'(o_q);
        out_valid_d = 1'b1;
        acc_d       = '0;
        i_d         = '0;
        if (o_q == OA'(OUT_CELL - 1)) begin
          state_d   = StIdle;
          all_end_d = 1'b1;
        end else begin
          o_d     = o_q + 1'b1;
          state_d = StMac;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      i_q         <= '0;
      o_q         <= '0;
      acc_q       <= '0;
      relu_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_value_q <= '0;
      all_end_q   <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      o_q         <= o_d;
      acc_q       <= acc_d;
      relu_q      <= relu_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_value_q <= out_value_d;
      all_end_q   <= all_end_d;
      load_err_q  <= load_err_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_value = out_value_q;
  assign all_end   = all_end_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_fc_layer_engine.sv
// Scoreboard bench for fc_layer_engine (IN_CELL=4, OUT_CELL=2): stimulus pushes expected results,
// a negedge monitor pops and compares each out_valid beat.
module tb_fc_layer_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        relu_en = 1'b0;
  logic        flat_we = 1'b0;
  logic [15:0] flat_addr = '0;
  logic [15:0] flat_value = '0;
  logic        wt_we = 1'b0;
  logic [15:0] wt_addr = '0;
  logic [15:0] wt_value = '0;
  logic        busy, out_valid, all_end, load_err;
  logic [15:0] out_addr, out_value;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] value;
    logic        last;
  } exp_t;
  exp_t sb[$];

  fc_layer_engine #(
    .IN_CELL  (4),
    .OUT_CELL (2),
    .DATA_W   (16),
    .FRAC_BITS(8),
    .ACC_W    (40)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .relu_en   (relu_en),
    .flat_we   (flat_we),
    .flat_addr (flat_addr),
    .flat_value(flat_value),
    .wt_we     (wt_we),
    .wt_addr   (wt_addr),
    .wt_value  (wt_value),
    .busy      (busy),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_value (out_value),
    .all_end   (all_end),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n && all_end) check("all_end_with_valid", {31'd0, out_valid}, 32'd1);
    if (reset_n && out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: addr %0h value %0h, expected no output",
                 out_addr, out_value);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_addr", {16'd0, out_addr}, {16'd0, e.addr});
        check("out_value", {16'd0, out_value}, {16'd0, e.value});
        check("all_end_on_last", {31'd0, all_end}, {31'd0, e.last});
      end
    end
  end

  task automatic do_write(input logic fw, input logic [15:0] fa, input logic [15:0] fv,
                          input logic ww, input logic [15:0] wa, input logic [15:0] wv);
    @(negedge clk);
    flat_we = fw; flat_addr = fa; flat_value = fv;
    wt_we = ww; wt_addr = wa; wt_value = wv;
    @(negedge clk);
    flat_we = 1'b0; wt_we = 1'b0;
    check("load_err_idle", {31'd0, load_err}, 32'd0);
  endtask

  task automatic load_basic();
    logic [15:0] x [4];
    x[0] = 16'h0100; x[1] = 16'h0200; x[2] = 16'hFF00; x[3] = 16'h0080;
    for (int i = 0; i < 4; i++) do_write(1'b1, 16'(i), x[i], 1'b1, 16'(i), 16'h0100);
    do_write(1'b0, 16'd0, 16'd0, 1'b1, 16'd4, 16'h0000);
    for (int i = 0; i < 4; i++) do_write(1'b0, 16'd0, 16'd0, 1'b1, 16'(5 + i), 16'hFF00);
    do_write(1'b0, 16'd0, 16'd0, 1'b1, 16'd9, 16'h0100);
  endtask

  // n counts cycles after the start-accepting edge E0 (n=0 is the cycle after E0).
  task automatic run_layer(input logic relu, input logic disturb, input int abort_at,
                           input logic [15:0] e0, input logic [15:0] e1);
    int n_busy = 0;
    int n_valid = 0;
    int n_end = 0;
    int n_lerr = 0;
    bit aborted = 0;
    exp_t e;
    e.addr = 16'd0; e.value = e0; e.last = 1'b0; sb.push_back(e);
    if (abort_at < 0 || abort_at >= 10) begin
      e.addr = 16'd1; e.value = e1; e.last = 1'b1; sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b1; relu_en = relu;
    @(posedge clk);
    #1 start = 1'b0; relu_en = 1'b0;
    for (int n = 0; n <= 12; n++) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (all_end) n_end++;
      if (load_err) n_lerr++;
      if (out_valid) begin
        check("valid_cycle", n, (n_valid == 0) ? 32'd5 : 32'd10);
        n_valid++;
      end
      flat_we = 1'b0; start = 1'b0;
      if (disturb && n == 2) begin
        flat_we = 1'b1; flat_addr = 16'd0; flat_value = 16'h7777; start = 1'b1;
      end
      if (disturb && n == 3) check("load_err_busy", {31'd0, load_err}, 32'd1);
      if (n == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_addr", {16'd0, out_addr}, 32'd0);
        check("abort_value", {16'd0, out_value}, 32'd0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("abort_no_all_end", {31'd0, all_end}, 32'd0);
        end
        reset_n = 1'b1;
        aborted = 1;
        break;
      end
    end
    if (!aborted) begin
      check("busy_cycles", n_busy, 32'd10);
      check("valid_count", n_valid, 32'd2);
      check("all_end_count", n_end, 32'd1);
      check("load_err_count", n_lerr, disturb ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #3 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_addr", {16'd0, out_addr}, 32'd0);
    check("rst_value", {16'd0, out_value}, 32'd0);
    check("rst_all_end", {31'd0, all_end}, 32'd0);
    check("rst_load_err", {31'd0, load_err}, 32'd0);
    reset_n = 1'b1;

    load_basic();
    run_layer(1'b0, 1'b0, -1, 16'h0280, 16'hFE80);
    run_layer(1'b1, 1'b0, -1, 16'h0280, 16'h0000);
    // Out-of-range weight address: silently dropped.
    do_write(1'b0, 16'd0, 16'd0, 1'b1, 16'd10, 16'h1234);
    run_layer(1'b0, 1'b1, -1, 16'h0280, 16'hFE80);
    run_layer(1'b0, 1'b0, 7, 16'h0280, 16'hFE80);
    run_layer(1'b0, 1'b0, -1, 16'h0280, 16'hFE80);

    for (int i = 0; i < 4; i++) do_write(1'b1, 16'(i), 16'h7FFF, 1'b0, 16'd0, 16'd0);
    for (int i = 0; i < 10; i++) do_write(1'b0, 16'd0, 16'd0, 1'b1, 16'(i), 16'h7FFF);
    run_layer(1'b0, 1'b0, -1, 16'h7FFF, 16'h7FFF);
    for (int i = 0; i < 4; i++) begin
      do_write(1'b0, 16'd0, 16'd0, 1'b1, 16'(i), 16'h8000);
      do_write(1'b0, 16'd0, 16'd0, 1'b1, 16'(5 + i), 16'h8000);
    end
    run_layer(1'b0, 1'b0, -1, 16'h8000, 16'h8000);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
